// File: rtl/hysteresis_threshold_if.sv
// Stream interface for hysteresis_threshold: NMS magnitude stream and thresholds
// going in, binary edge pixels and per-frame statistics coming out.
interface hysteresis_threshold_if #(
  parameter int MAG_W = 11
);
  logic [MAG_W-1:0] nms_magnitude;
  logic             nms_valid;
  logic [MAG_W-1:0] low_threshold;
  logic [MAG_W-1:0] high_threshold;
  logic [7:0]       edge_pixel_out;
  logic             edge_pixel_out_valid;
  logic             frame_done;
  logic [18:0]      edge_count;

  modport master (
    output nms_magnitude, nms_valid, low_threshold, high_threshold,
    input  edge_pixel_out, edge_pixel_out_valid, frame_done, edge_count
  );

  modport slave (
    input  nms_magnitude, nms_valid, low_threshold, high_threshold,
    output edge_pixel_out, edge_pixel_out_valid, frame_done, edge_count
  );
endinterface

// File: rtl/hysteresis_threshold.sv
// Final Canny stage: double threshold plus single-pass causal hysteresis over a
// raster stream, using a 1-bit line buffer of the previous row's final decisions.
module hysteresis_threshold #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int MAG_W      = 11
) (
  input  logic                  clk,
  input  logic                  rstN,
  hysteresis_threshold_if.slave bus
);
  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int CNT_W = 19;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col_next;
  logic [MAG_W-1:0] lo_r, hi_r;
  logic [MAG_W-1:0] lo_p0, hi_p0, mag_p0;
  logic             frame_start, last_col, last_row;
  logic             strong_p0, weak_p0;
  logic             nb_l_p0, nb_ul_p0, nb_u_p0, nb_ur_p0, edge_p0;
  logic             line_buf [IMG_WIDTH];
  logic             ul_r, left_r;
  logic [CNT_W-1:0] run_cnt, cnt_next;

  logic [7:0]       pix_p1;
  logic             vld_p1;
  logic             done_p1;
  logic [CNT_W-1:0] edge_count_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && (c != {CNT_W{1'b1}}))
      return c + 1'b1;
    return c;
  endfunction

  // Stage p0: classify the incoming pixel against the causal neighbourhood
  always_comb begin
    mag_p0      = bus.nms_magnitude;
    frame_start = (row == '0) && (col == '0);
    last_col    = (col == COL_W'(IMG_WIDTH - 1));
    last_row    = (row == ROW_W'(IMG_HEIGHT - 1));
    col_next    = col + 1'b1;

    // The (0,0) pixel already uses the thresholds it is sampling.
    if (frame_start) begin
      lo_p0 = (bus.low_threshold <= bus.high_threshold) ? bus.low_threshold  : bus.high_threshold;
      hi_p0 = (bus.low_threshold <= bus.high_threshold) ? bus.high_threshold : bus.low_threshold;
    end else begin
      lo_p0 = lo_r;
      hi_p0 = hi_r;
    end

    strong_p0 = (mag_p0 >= hi_p0);
    weak_p0   = !strong_p0 && (mag_p0 >= lo_p0);

    // Row 0 masks whatever the line buffer holds from the previous frame.
    nb_l_p0  = (col != '0) && left_r;
    nb_ul_p0 = (col != '0) && (row != '0) && ul_r;
    nb_u_p0  = (row != '0) && line_buf[col];
    nb_ur_p0 = !last_col && (row != '0) && line_buf[col_next];

    edge_p0  = strong_p0 || (weak_p0 && (nb_l_p0 || nb_ul_p0 || nb_u_p0 || nb_ur_p0));
    cnt_next = sat_inc(run_cnt, edge_p0);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      col           <= '0;
      row           <= '0;
      lo_r          <= '0;
      hi_r          <= '0;
      run_cnt       <= '0;
      pix_p1        <= '0;
      vld_p1        <= 1'b0;
      done_p1       <= 1'b0;
      edge_count_p1 <= '0;
    end else begin
      vld_p1  <= bus.nms_valid;
      done_p1 <= 1'b0;
      if (bus.nms_valid) begin
        pix_p1 <= edge_p0 ? 8'hFF : 8'h00;
        if (frame_start) begin
          lo_r <= lo_p0;
          hi_r <= hi_p0;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col_next;
        end
        if (last_col && last_row) begin
          done_p1       <= 1'b1;
          edge_count_p1 <= cnt_next;
          run_cnt       <= '0;
        end else begin
          run_cnt <= cnt_next;
        end
      end
    end
  end

  // ul_r captures the old U entry before it is overwritten; it is UL for the next column.
  always_ff @(posedge clk) begin
    if (bus.nms_valid) begin
      line_buf[col] <= edge_p0;
      ul_r          <= line_buf[col];
      left_r        <= edge_p0;
    end
  end

  // Stage p1: registered outputs
  assign bus.edge_pixel_out       = pix_p1;
  assign bus.edge_pixel_out_valid = vld_p1;
  assign bus.frame_done           = done_p1;
  assign bus.edge_count           = edge_count_p1;
endmodule

// File: tb/tb_hysteresis_threshold.sv
// Directed bench for hysteresis_threshold on a 4x2 image.
module tb_hysteresis_threshold;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int MW = 11;

  logic clk = 1'b0;
  logic rstN;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hysteresis_threshold_if #(.MAG_W(MW)) bus ();

  hysteresis_threshold #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_W(MW)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  task automatic send_frame(input string name, input int m [8], input logic [7:0] mask,
                            input int exp_cnt, input int max_idle, input bit scramble);
    logic [7:0] expv;
    int         idles;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.nms_valid     = 1'b1;
      bus.nms_magnitude = MW'(m[i]);
      @(posedge clk);
      #1;
      if (scramble && i == 0) begin
        bus.low_threshold  = 11'd100;
        bus.high_threshold = 11'd200;
      end
      expv = mask[i] ? 8'hFF : 8'h00;
      n_cmp++;
      if (bus.edge_pixel_out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL %s px%0d valid: got %b want 1", name, i, bus.edge_pixel_out_valid);
      end
      n_cmp++;
      if (bus.edge_pixel_out !== expv) begin
        n_err++;
        $display("FAIL %s px%0d pixel: got %h want %h", name, i, bus.edge_pixel_out, expv);
      end
      n_cmp++;
      if (bus.frame_done !== (i == 7)) begin
        n_err++;
        $display("FAIL %s px%0d frame_done: got %b want %b", name, i, bus.frame_done, (i == 7));
      end
      if (i == 7) begin
        n_cmp++;
        if (bus.edge_count !== 19'(exp_cnt)) begin
          n_err++;
          $display("FAIL %s edge_count: got %0d want %0d", name, bus.edge_count, exp_cnt);
        end
      end
      idles = (max_idle > 0) ? int'($urandom_range(0, max_idle)) : 0;
      for (int k = 0; k < idles; k++) begin
        @(negedge clk);
        bus.nms_valid = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.edge_pixel_out_valid !== 1'b0 || bus.edge_pixel_out !== expv) begin
          n_err++;
          $display("FAIL %s idle after px%0d: got valid=%b pix=%h want valid=0 pix=%h",
                   name, i, bus.edge_pixel_out_valid, bus.edge_pixel_out, expv);
        end
      end
    end
    @(negedge clk);
    bus.nms_valid = 1'b0;
    if (scramble) begin
      bus.low_threshold  = 11'd10;
      bus.high_threshold = 11'd20;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (bus.edge_pixel_out !== 8'h00 || bus.edge_pixel_out_valid !== 1'b0 ||
        bus.frame_done !== 1'b0 || bus.edge_count !== 19'd0) begin
      n_err++;
      $display("FAIL %s: got pix=%h valid=%b done=%b cnt=%0d want all 0", name,
               bus.edge_pixel_out, bus.edge_pixel_out_valid, bus.frame_done, bus.edge_count);
    end
  endtask

  task automatic test_reset();
    rstN               = 1'b0;
    bus.nms_valid      = 1'b0;
    bus.nms_magnitude  = '0;
    bus.low_threshold  = 11'd10;
    bus.high_threshold = 11'd20;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_all_strong();
    int m [8] = '{25, 25, 25, 25, 25, 25, 25, 25};
    send_frame("all_strong", m, 8'hFF, 8, 0, 1'b1);
  endtask

  task automatic test_isolated_weak();
    int m [8] = '{15, 15, 15, 15, 15, 15, 15, 15};
    send_frame("isolated_weak", m, 8'h00, 0, 0, 1'b0);
  endtask

  task automatic test_promotion();
    int m [8] = '{25, 15, 15, 5, 5, 5, 5, 15};
    send_frame("promotion", m, 8'h87, 4, 0, 1'b0);
  endtask

  task automatic test_boundaries();
    int m1 [8] = '{20, 9, 10, 0, 0, 0, 0, 0};
    int m2 [8] = '{15, 15, 15, 15, 15, 15, 15, 15};
    send_frame("boundaries", m1, 8'h01, 1, 0, 1'b0);
    bus.low_threshold  = 11'd20;
    bus.high_threshold = 11'd10;
    send_frame("swapped_thr", m2, 8'h00, 0, 0, 1'b0);
    bus.low_threshold  = 11'd10;
    bus.high_threshold = 11'd20;
  endtask

  task automatic test_idle_gaps();
    int m [8] = '{25, 15, 15, 5, 5, 5, 5, 15};
    send_frame("idle_gaps", m, 8'h87, 4, 3, 1'b0);
  endtask

  task automatic test_mid_frame_reset();
    int m [8] = '{15, 25, 25, 25, 25, 25, 25, 25};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.nms_valid     = 1'b1;
      bus.nms_magnitude = 11'd25;
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.edge_pixel_out !== 8'hFF || bus.edge_pixel_out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL pre_reset px%0d: got pix=%h valid=%b want FF 1", i,
                 bus.edge_pixel_out, bus.edge_pixel_out_valid);
      end
    end
    @(negedge clk);
    bus.nms_valid = 1'b0;
    rstN          = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    @(negedge clk);
    rstN = 1'b1;
    send_frame("after_reset", m, 8'hFE, 7, 0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_strong();
    test_isolated_weak();
    test_promotion();
    test_boundaries();
    test_idle_gaps();
    test_mid_frame_reset();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
